// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM lock controller, FSM and display.
// ATM_LOCK_ESCALATE_EN widens the lock timer so long locks can escalate.
package atm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED  = 2'd1,
        RELEASE = 2'd2
    } lock_state_t;

    localparam logic LOCK_KIND_SHORT = 1'b0;
    localparam logic LOCK_KIND_LONG  = 1'b1;

    // Board values: 0.1 s ticks at 100 MHz, 5 s long lock, 2.5 s short lock.
    localparam int HW_TICK_DIV    = 10_000_000;
    localparam int HW_LONG_TICKS  = 50;
    localparam int HW_SHORT_TICKS = 25;
    localparam int HW_MAX_FAILS   = 3;

`ifdef ATM_LOCK_ESCALATE_EN
    localparam int ESC_BITS = 2;
`else
    localparam int ESC_BITS = 0;
`endif

endpackage

// File: rtl/atm_tick_prescaler.sv
// Free-running tick divider: one-cycle tick every TICK_DIV cycles while clr is low.
// Held at zero while clr is high so the first tick lands TICK_DIV cycles after release.
module atm_tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/atm_lock_ctrl.sv
// Lockout scheduler: counts consecutive password failures and times long/short locks.
// Define ATM_LOCK_ESCALATE_EN to double successive long locks (1x, 2x, 4x, 4x ...).
module atm_lock_ctrl
    import atm_pkg::*;
#(
    parameter int TICK_DIV    = 1,
    parameter int LONG_TICKS  = 64,
    parameter int SHORT_TICKS = 32,
    parameter int MAX_FAILS   = 3,
    localparam int FW = $clog2(MAX_FAILS + 1),
    localparam int RW = $clog2(LONG_TICKS + 1) + ESC_BITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pw_fail,
    input  logic          pw_ok,
    input  logic          insuff,
    input  logic          logout,
    output logic          locked,
    output logic          lock_long,
    output logic          force_logout,
    output logic          lock_done,
    output logic [FW-1:0] fail_cnt,
    output logic [RW-1:0] remain
);

    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);

    lock_state_t   state;
    logic          tick;
    logic [RW-1:0] long_load;

    atm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != LOCKED),
        .tick (tick)
    );

`ifdef ATM_LOCK_ESCALATE_EN
    logic [1:0] esc_lvl;
    assign long_load = RW'(LONG_TICKS) << esc_lvl;
`else
    assign long_load = RW'(LONG_TICKS);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            locked       <= 1'b0;
            lock_long    <= LOCK_KIND_SHORT;
            force_logout <= 1'b0;
            lock_done    <= 1'b0;
            fail_cnt     <= '0;
            remain       <= '0;
`ifdef ATM_LOCK_ESCALATE_EN
            esc_lvl      <= 2'd0;
`endif
        end else begin
            force_logout <= 1'b0;
            lock_done    <= 1'b0;
            case (state)
                IDLE: begin
                    // Strict priority: lower strobes in the same cycle are dropped.
                    if (pw_fail) begin
                        if (fail_cnt >= FAIL_LAST) begin
                            state        <= LOCKED;
                            locked       <= 1'b1;
                            lock_long    <= LOCK_KIND_LONG;
                            fail_cnt     <= FAIL_MAX;
                            remain       <= long_load;
                            force_logout <= 1'b1;
`ifdef ATM_LOCK_ESCALATE_EN
                            if (esc_lvl != 2'd2) esc_lvl <= esc_lvl + 2'd1;
`endif
                        end else begin
                            fail_cnt <= fail_cnt + FW'(1);
                        end
                    end else if (insuff) begin
                        state     <= LOCKED;
                        locked    <= 1'b1;
                        lock_long <= LOCK_KIND_SHORT;
                        remain    <= RW'(SHORT_TICKS);
                    end else if (pw_ok) begin
                        fail_cnt <= '0;
`ifdef ATM_LOCK_ESCALATE_EN
                        esc_lvl  <= 2'd0;
`endif
                    end else if (logout) begin
                        fail_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (tick) begin
                        // <=1 also covers a zero-length load, so remain never wraps.
                        if (remain <= RW'(1)) begin
                            remain    <= '0;
                            state     <= RELEASE;
                            locked    <= 1'b0;
                            lock_done <= 1'b1;
                            if (lock_long) fail_cnt <= '0;
                        end else begin
                            remain <= remain - RW'(1);
                        end
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_lock_ctrl.sv
// Directed bench for atm_lock_ctrl with TICK_DIV=2, LONG_TICKS=4, SHORT_TICKS=2, MAX_FAILS=3.
module tb_atm_lock_ctrl;
    import atm_pkg::*;

    localparam int RW = $clog2(4 + 1) + ESC_BITS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pw_fail = 1'b0, pw_ok = 1'b0, insuff = 1'b0, logout = 1'b0;
    logic          locked, lock_long, force_logout, lock_done;
    logic [1:0]    fail_cnt;
    logic [RW-1:0] remain;

    int n_chk  = 0;
    int n_pass = 0;

    atm_lock_ctrl #(
        .TICK_DIV(2), .LONG_TICKS(4), .SHORT_TICKS(2), .MAX_FAILS(3)
    ) dut (
        .clk(clk), .rst(rst), .pw_fail(pw_fail), .pw_ok(pw_ok), .insuff(insuff),
        .logout(logout), .locked(locked), .lock_long(lock_long),
        .force_logout(force_logout), .lock_done(lock_done),
        .fail_cnt(fail_cnt), .remain(remain)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive strobes for exactly one edge, then sample the registered result.
    task automatic pulse(input logic f, input logic i, input logic o, input logic l);
        pw_fail = f; insuff = i; pw_ok = o; logout = l;
        step();
        pw_fail = 1'b0; insuff = 1'b0; pw_ok = 1'b0; logout = 1'b0;
    endtask

    // Called on the first locked cycle; returns on the cycle locked drops.
    task automatic measure(input int ticks, output int n, output int rem_err, output int fl);
        n = 0; rem_err = 0; fl = 0;
        while (locked && n < 200) begin
            if (int'(remain) != ticks - n / 2) rem_err++;
            if (force_logout) fl++;
            n++;
            step();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_lock_long"}, lock_long, 0);
        chk({tag, "_force_logout"}, force_logout, 0);
        chk({tag, "_lock_done"}, lock_done, 0);
        chk({tag, "_fail_cnt"}, fail_cnt, 0);
        chk({tag, "_remain"}, remain, 0);
    endtask

    initial begin
        int n, re, fl;

        step(); step();
        chk_reset_vals("rst");
        rst = 1'b1;
        step();

        // 1: three spaced failures -> long lock of 8 cycles
        pulse(1, 0, 0, 0); chk("t1_cnt1", fail_cnt, 1);
        repeat (4) step();
        pulse(1, 0, 0, 0); chk("t1_cnt2", fail_cnt, 2);
        repeat (4) step();
        pulse(1, 0, 0, 0);
        chk("t1_locked", locked, 1);
        chk("t1_long", lock_long, 1);
        chk("t1_cnt3", fail_cnt, 3);
        chk("t1_fl_first", force_logout, 1);
        measure(4, n, re, fl);
        chk("t1_len", n, 8);
        chk("t1_remain_trace", re, 0);
        chk("t1_fl_pulses", fl, 1);
        chk("t1_done", lock_done, 1);
        chk("t1_remain0", remain, 0);
        chk("t1_cnt_clr", fail_cnt, 0);
        step();
        chk("t1_done_pulse", lock_done, 0);
        chk("t1_long_held", lock_long, 1);

        // 2: short lock keeps the failure count
        pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
        chk("t2_cnt2", fail_cnt, 2);
        pulse(0, 1, 0, 0);
        chk("t2_locked", locked, 1);
        chk("t2_short", lock_long, 0);
        chk("t2_remain", remain, 2);
        measure(2, n, re, fl);
        chk("t2_len", n, 4);
        chk("t2_remain_trace", re, 0);
        chk("t2_no_fl", fl, 0);
        chk("t2_done", lock_done, 1);
        chk("t2_cnt_kept", fail_cnt, 2);
        step();

        // 3: pw_ok resets the count
        pulse(0, 0, 1, 0); chk("t3_ok0", fail_cnt, 0);
        pulse(1, 0, 0, 0); chk("t3_c1", fail_cnt, 1);
        pulse(1, 0, 0, 0); chk("t3_c2", fail_cnt, 2);
        pulse(0, 0, 1, 0); chk("t3_c0", fail_cnt, 0);
        pulse(1, 0, 0, 0); chk("t3_c1b", fail_cnt, 1);
        chk("t3_unlocked", locked, 0);

        // 4: pw_fail beats insuff in the same cycle
        pulse(1, 0, 0, 0);
        pulse(1, 1, 0, 0);
        chk("t4_long", lock_long, 1);
        chk("t4_fl", force_logout, 1);
        chk("t4_remain", remain, 4);
        measure(4, n, re, fl);
        chk("t4_len", n, 8);
        step();
        chk("t4_cnt0", fail_cnt, 0);

        // 5: strobes during LOCKED and RELEASE are ignored
        pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        chk("t5_locked", locked, 1);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        chk("t5_still_locked", locked, 1);
        pulse(1, 0, 0, 0);
        chk("t5_done_on_time", lock_done, 1);
        chk("t5_cnt_kept", fail_cnt, 2);
        pulse(1, 1, 1, 0);
        chk("t5_no_relock", locked, 0);
        chk("t5_cnt_release", fail_cnt, 2);
        step();
        chk("t5_idle", locked, 0);

        // 6: reset during the 3rd cycle of a long lock
        pulse(1, 0, 0, 0);
        chk("t6_locked", locked, 1);
        step(); step();
        rst = 1'b0;
        step();
        chk_reset_vals("t6");
        rst = 1'b1;
        step();
        chk("t6_no_done", lock_done, 0);
        chk("t6_idle", locked, 0);

`ifdef ATM_LOCK_ESCALATE_EN
        // 7: escalating long locks, reset by pw_ok
        for (int s = 0; s < 3; s++) begin
            repeat (3) pulse(1, 0, 0, 0);
            measure(4 << s, n, re, fl);
            chk("t7_len", n, 8 << s);
            chk("t7_remain_trace", re, 0);
            step();
        end
        repeat (3) pulse(1, 0, 0, 0);
        measure(16, n, re, fl);
        chk("t7_sat_len", n, 32);
        step();
        pulse(0, 0, 1, 0);
        repeat (3) pulse(1, 0, 0, 0);
        measure(4, n, re, fl);
        chk("t7_ok_reset_len", n, 8);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/atm_lock_ctrl.md
Name: atm_lock_ctrl

Overview:
- Lockout scheduler for the ATM datapath FSM. It counts consecutive wrong-password events and times the two lock periods: a long lock after MAX_FAILS failures and a short lock after an insufficient-balance withdrawal.
- It gates the FSM through `locked`, requests logout through `force_logout`, and exports remaining lock time for the 7-segment display.
- It sits between the ATM FSM's event strobes and its state-advance logic.

Parameters:
- TICK_DIV, 1, clk cycles per timer tick (hardware: 10_000_000 for 0.1 s at 100 MHz).
- LONG_TICKS, 64, ticks in the long lock (hardware: 50 = 5 s).
- SHORT_TICKS, 32, ticks in the short lock (hardware: 25 = 2.5 s); must be ≤ LONG_TICKS.
- MAX_FAILS, 3, consecutive failures that trigger the long lock.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- pw_fail  in  1  one-cycle strobe: password rejected (login or change-password check).
- pw_ok  in  1  one-cycle strobe: password accepted.
- insuff  in  1  one-cycle strobe: withdrawal exceeded balance.
- logout  in  1  one-cycle strobe: user logged out.
- locked  out  1  high while a lock is active; the FSM ignores buttons while it is high.
- lock_long  out  1  1 = current/last lock was long; 0 = short.
- force_logout  out  1  one-cycle pulse on long-lock entry.
- lock_done  out  1  one-cycle pulse when a lock expires.
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failure count.
- remain  out  RW  ticks left in the lock. RW = $clog2(LONG_TICKS+1), or +2 bits with the escalation feature.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-low.
- Reset (`rst` == 0 at a clk edge): state=IDLE; `locked`=0, `lock_long`=0, `force_logout`=0, `lock_done`=0, `fail_cnt`=0, `remain`=0, prescaler=0.
- States: IDLE, LOCKED, RELEASE.
- Events are sampled in IDLE only. Priority within one cycle: pw_fail > insuff > pw_ok > logout. Lower-priority strobes in the same cycle are dropped.
- IDLE, pw_fail with fail_cnt < MAX_FAILS-1: fail_cnt+1 next cycle.
- IDLE, pw_fail with fail_cnt == MAX_FAILS-1: next cycle state=LOCKED, `locked`=1, `lock_long`=1, `fail_cnt`=MAX_FAILS, `remain`=LONG_TICKS, `force_logout`=1 for that cycle only, prescaler=0.
- IDLE, insuff: next cycle state=LOCKED, `locked`=1, `lock_long`=0, `remain`=SHORT_TICKS, prescaler=0. `fail_cnt` unchanged; no `force_logout`.
- IDLE, pw_ok or logout: `fail_cnt`=0 next cycle.
- LOCKED, prescaler: counts 0..TICK_DIV-1 and raises `tick` when it equals TICK_DIV-1, then wraps to 0. With TICK_DIV==1, `tick` is high every cycle.
- LOCKED, countdown: each `tick` decrements `remain`. When `tick` fires with `remain`==1: `remain`=0, state=RELEASE.
- LOCKED, duration: `locked` is high for exactly TICKS*TICK_DIV cycles.
- LOCKED, inputs: all event strobes are ignored (not queued).
- RELEASE, one cycle: `locked`=0, `lock_done`=1. If `lock_long`, `fail_cnt` clears to 0.
- RELEASE, exit and inputs: returns to IDLE. Events in this cycle are ignored.
- `lock_long` holds its value after release until the next lock entry.
- Reset mid-lock aborts immediately to reset values; no `lock_done` pulse.
- Arithmetic: `remain` never underflows. The prescaler width is $clog2(TICK_DIV) with a minimum of 1 bit.

Optional Feature:
- ATM_LOCK_ESCALATE_EN defined:
  - A 2-bit `esc_lvl` counts long locks since the last pw_ok, saturating at 2.
  - Long-lock load = LONG_TICKS << esc_lvl, using the pre-increment value, so durations are 1x, 2x, 4x, 4x...
  - `esc_lvl` clears on pw_ok and on reset only.
  - RW gains 2 bits.
- ATM_LOCK_ESCALATE_EN undefined: every long lock loads LONG_TICKS; no `esc_lvl` register.

Decomposition:
- Package atm_pkg holds:
  - the state enum (IDLE, LOCKED, RELEASE);
  - LOCK_KIND_SHORT=0 and LOCK_KIND_LONG=1 constants;
  - the default tick constants shared with the ATM FSM and display.
- One sub-module, atm_tick_prescaler:
  - ports clk, rst, clr, tick;
  - parameter TICK_DIV;
  - also reusable by the display blink logic.

Test Plan (TICK_DIV=2, LONG_TICKS=4, SHORT_TICKS=2, MAX_FAILS=3):
1. Three pw_fail strobes 5 cycles apart -> `fail_cnt` goes 1, 2, 3. `force_logout` is a single pulse on the cycle after the 3rd. `locked` is high for exactly 8 cycles with `remain` 4→0. Then a `lock_done` pulse, `fail_cnt`=0.
2. insuff in IDLE with `fail_cnt`=2 -> `locked` high for 4 cycles, `lock_long`=0, no `force_logout`. After `lock_done`, `fail_cnt` is still 2.
3. pw_fail, pw_fail, pw_ok, pw_fail -> `fail_cnt` reads 1, 2, 0, 1; no lock.
4. pw_fail and insuff in the same cycle with `fail_cnt`=2 -> long lock taken; insuff dropped.
5. pw_fail, insuff and pw_ok pulsed during LOCKED and RELEASE -> no effect: duration unchanged, `fail_cnt` unchanged, no relock.
6. `rst` low for one edge at the 3rd cycle of a long lock -> all outputs return to reset values next cycle, no `lock_done`.
7. With ATM_LOCK_ESCALATE_EN, three successive 3-fail sequences -> lock lengths of 8, 16 and 32 cycles. A pw_ok after the first lock releases resets the next length to 8.
